lif_scheduler: RTL and testbench
================================

LIF_SCHEDULER -- requirements
Module: lif_scheduler

Interface
REQ-001 Parameter NUM_NEUR, default 4, number of virtual neurons time-multiplexed through one shared LIF update datapath; fixed at 4 for this release.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 ena  input  1  design enable; low freezes all state (no updates, no config writes, no tick acceptance).
REQ-005 tick  input  1  start one time step; sampled per cycle.
REQ-006 cur_in  input  32  four 8-bit unsigned input currents, neuron k in bits [8k+7:8k]; latched on tick acceptance.
REQ-007 cfg_we  input  1  configuration write strobe.
REQ-008 cfg_addr  input  2  0=THRESH, 1=LEAK_SH, 2=REFRAC, 3=reserved.
REQ-009 cfg_data  input  8  write data; LEAK_SH uses [2:0], REFRAC uses [3:0].
REQ-010 mon_sel  input  2  neuron index for membrane monitor.
REQ-011 v_mon  output  8  combinational read of membrane potential of neuron mon_sel.
REQ-012 busy  output  1  high while a time step is in progress.
REQ-013 done  output  1  one-cycle pulse at end of time step.
REQ-014 spikes  output  4  registered spike vector of last completed step; bit k = neuron k.

Function
REQ-015 FSM states IDLE, UPD, FIN; IDLE->UPD on tick&ena; UPD serves idx 0..3, one neuron per cycle; UPD(idx=3)->FIN; FIN->IDLE unconditionally.
REQ-016 Latency: tick accepted at edge T; neuron k written at edge T+1+k; done high and spikes valid in the cycle after edge T+4 (FIN); busy high from edge T through FIN.
REQ-017 tick while busy ignored (not queued); tick held high in FIN is not accepted until IDLE.
REQ-018 cur_in latched only at tick acceptance; later changes do not affect the running step.
REQ-019 Refractory neuron (rcnt[k]!=0): v[k] stays 0, rcnt[k] decrements by 1, no spike.
REQ-020 Otherwise: sum = v - (v >> LEAK_SH) + cur, computed 9 bits wide, saturated to 255.
REQ-021 LEAK_SH=0 yields full leak (v - v = 0), sum = cur.
REQ-022 Spike when saturated sum >= THRESH: spike bit set, v[k]=0, rcnt[k]=REFRAC; else v[k]=sum, bit clear.
REQ-023 THRESH=0: every non-refractory neuron spikes each step; REFRAC=0: no refractory period.
REQ-024 Spike bits accumulate during UPD into a shadow vector; spikes output updates only on entry to FIN and holds until the next FIN.
REQ-025 Config writes accepted only when ena=1 and state IDLE; writes while busy or to addr 3 silently dropped; a write coincident with tick acceptance is applied and governs that step.
REQ-026 ena low mid-step: FSM, idx, v, rcnt, outputs hold; resume on same idx when ena returns; done not emitted while ena low.

Reset
REQ-027 rst_n low asynchronously forces: state IDLE, idx 0, all v=0, all rcnt=0, spikes=0, done=0, busy=0, THRESH=200, LEAK_SH=2, REFRAC=3; reset mid-step abandons the step with no done pulse.

Verification
REQ-028 Defaults, cur0=100, others 0, ticks 1..7 -> v0 = 100, 175, then spike on tick 3 (v0=0), ticks 4-6 no spike with rcnt 2,1,0, tick 7 v0=100; neurons 1-3 stay 0.
REQ-029 THRESH=255, LEAK_SH=7, cur1=200 -> tick 1 v1=200, tick 2 sum 399 saturates to 255, spike bit1, v1=0.
REQ-030 Single tick -> busy rises at edge T, done single pulse in cycle after T+4, spikes stable until next FIN; tick pulsed during busy produces no extra step.
REQ-031 cfg write THRESH=50 while busy -> dropped, readback via behaviour shows THRESH=200 next step; same write in IDLE -> cur0=60 spikes on first tick.
REQ-032 ena dropped for 3 cycles after neuron 1 update -> no state change during gap, done arrives 3 cycles late, v values identical to uninterrupted run.
REQ-033 rst_n asserted mid-UPD after v0=175 -> immediate IDLE, v_mon=0 for all mon_sel, no done pulse, config back to defaults.

Source files
------------

// File: rtl/lif_scheduler.sv
// Time-multiplexed leaky integrate-and-fire scheduler.
// One shared LIF datapath updates NUM_NEUR neurons per tick; config regs set threshold, leak, refractory.
// Ports: clk, rst_n, ena, tick, cur_in[8*N], cfg_we/addr/data, mon_sel -> v_mon, busy, done, spikes.
module lif_scheduler #(
  parameter int NUM_NEUR = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  tick,
  input  logic [8*NUM_NEUR-1:0] cur_in,
  input  logic                  cfg_we,
  input  logic [1:0]            cfg_addr,
  input  logic [7:0]            cfg_data,
  input  logic [1:0]            mon_sel,
  output logic [7:0]            v_mon,
  output logic                  busy,
  output logic                  done,
  output logic [NUM_NEUR-1:0]   spikes
);

  localparam int IW = $clog2(NUM_NEUR);

  typedef enum logic [1:0] {
    S_IDLE,
    S_UPD,
    S_FIN
  } state_e;

  state_e              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [7:0]          v_q [NUM_NEUR];
  logic [7:0]          v_d [NUM_NEUR];
  logic [3:0]          rcnt_q [NUM_NEUR];
  logic [3:0]          rcnt_d [NUM_NEUR];
  logic [7:0]          cur_q [NUM_NEUR];
  logic [7:0]          cur_d [NUM_NEUR];
  logic [NUM_NEUR-1:0] shadow_q, shadow_d;
  logic [NUM_NEUR-1:0] spikes_q, spikes_d;
  logic [7:0]          thresh_q, thresh_d;
  logic [2:0]          leak_q, leak_d;
  logic [3:0]          refrac_q, refrac_d;

  logic [7:0] v_cur;
  logic [3:0] r_cur;
  logic [7:0] c_cur;
  logic [7:0] leak_v;
  logic [8:0] sum9;
  logic [7:0] sat;
  logic       refr;
  logic       fire;

  // Shared datapath, operating on the neuron selected by idx_q
  always_comb begin
    v_cur  = v_q[idx_q];
    r_cur  = rcnt_q[idx_q];
    c_cur  = cur_q[idx_q];
    // shift of 0 gives v - v = 0: full leak
    leak_v = v_cur - (v_cur >> leak_q);
    sum9   = {1'b0, leak_v} + {1'b0, c_cur};
    sat    = sum9[8] ? 8'hff : sum9[7:0];
    refr   = (r_cur != 4'd0);
    fire   = !refr && (sat >= thresh_q);
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    v_d      = v_q;
    rcnt_d   = rcnt_q;
    cur_d    = cur_q;
    shadow_d = shadow_q;
    spikes_d = spikes_q;
    thresh_d = thresh_q;
    leak_d   = leak_q;
    refrac_d = refrac_q;
    if (ena) begin
      unique case (state_q)
        S_IDLE: begin
          // a write in the same cycle as tick lands before the first update
          if (cfg_we) begin
            case (cfg_addr)
              2'd0:    thresh_d = cfg_data;
              2'd1:    leak_d   = cfg_data[2:0];
              2'd2:    refrac_d = cfg_data[3:0];
              default: ;
            endcase
          end
          if (tick) begin
            state_d  = S_UPD;
            idx_d    = '0;
            shadow_d = '0;
            for (int k = 0; k < NUM_NEUR; k++) begin
              cur_d[k] = cur_in[8*k +: 8];
            end
          end
        end
        S_UPD: begin
          if (refr) begin
            v_d[idx_q]    = 8'd0;
            rcnt_d[idx_q] = r_cur - 4'd1;
          end else if (fire) begin
            v_d[idx_q]    = 8'd0;
            rcnt_d[idx_q] = refrac_q;
          end else begin
            v_d[idx_q]    = sat;
          end
          shadow_d[idx_q] = fire;
          if (idx_q == IW'(NUM_NEUR - 1)) begin
            state_d  = S_FIN;
            idx_d    = '0;
            spikes_d = shadow_d;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
        S_FIN: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      shadow_q <= '0;
      spikes_q <= '0;
      thresh_q <= 8'd200;
      leak_q   <= 3'd2;
      refrac_q <= 4'd3;
      for (int k = 0; k < NUM_NEUR; k++) begin
        v_q[k]    <= 8'd0;
        rcnt_q[k] <= 4'd0;
        cur_q[k]  <= 8'd0;
      end
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      spikes_q <= spikes_d;
      thresh_q <= thresh_d;
      leak_q   <= leak_d;
      refrac_q <= refrac_d;
      for (int k = 0; k < NUM_NEUR; k++) begin
        v_q[k]    <= v_d[k];
        rcnt_q[k] <= rcnt_d[k];
        cur_q[k]  <= cur_d[k];
      end
    end
  end

  assign v_mon  = v_q[mon_sel];
  assign busy   = (state_q != S_IDLE);
  // gated so a frozen FIN does not stretch the pulse
  assign done   = (state_q == S_FIN) && ena;
  assign spikes = spikes_q;

endmodule

// File: tb/tb_lif_scheduler.sv
// Testbench for lif_scheduler.
// Directed and random steps checked against a per-step behavioural LIF model.
module tb_lif_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b1;
  logic        tick = 1'b0;
  logic [31:0] cur_in = '0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_addr = '0;
  logic [7:0]  cfg_data = '0;
  logic [1:0]  mon_sel = '0;
  logic [7:0]  v_mon;
  logic        busy;
  logic        done;
  logic [3:0]  spikes;

  lif_scheduler #(.NUM_NEUR(4)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .tick(tick),
    .cur_in(cur_in), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .mon_sel(mon_sel), .v_mon(v_mon),
    .busy(busy), .done(done), .spikes(spikes)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  int m_v [4];
  int m_r [4];
  int m_th, m_sh, m_rf;
  logic [3:0] m_spk, m_prev;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    for (int k = 0; k < 4; k++) begin
      m_v[k] = 0;
      m_r[k] = 0;
    end
    m_th = 200; m_sh = 2; m_rf = 3;
    m_spk = '0; m_prev = '0;
  endfunction

  function automatic void m_step(input logic [31:0] cur);
    int s;
    m_prev = m_spk;
    m_spk = '0;
    for (int k = 0; k < 4; k++) begin
      if (m_r[k] > 0) begin
        m_v[k] = 0;
        m_r[k] = m_r[k] - 1;
      end else begin
        s = m_v[k] - (m_v[k] >> m_sh) + int'(cur[8*k +: 8]);
        if (s > 255) s = 255;
        if (s >= m_th) begin
          m_spk[k] = 1'b1;
          m_v[k] = 0;
          m_r[k] = m_rf;
        end else begin
          m_v[k] = s;
        end
      end
    end
  endfunction

  task automatic check_all(input string tag);
    for (int k = 0; k < 4; k++) begin
      mon_sel = 2'(k);
      #1;
      chk($sformatf("%s_v%0d", tag, k), 32'(v_mon), 32'(m_v[k]));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    tick = 1'b0; cfg_we = 1'b0; ena = 1'b1;
    m_reset();
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_spk", 32'(spikes), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic cfg_wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0;
    case (a)
      2'd0: m_th = int'(d);
      2'd1: m_sh = int'(d[2:0]);
      2'd2: m_rf = int'(d[3:0]);
      default: ;
    endcase
  endtask

  // act: 0 plain, 1 ena gap of 3 cycles, 2 cfg write while busy,
  // 3 extra tick while busy
  task automatic run_step(input logic [31:0] cur, input int act);
    int lat;
    int exp_lat;
    logic [7:0] snap;
    bit got;
    exp_lat = (act == 1) ? 8 : 5;
    snap = '0;
    got = 0;
    @(negedge clk);
    tick = 1'b1; cur_in = cur;
    @(posedge clk);
    #1;
    tick = 1'b0; cur_in = $urandom;
    m_step(cur);
    chk("busy_rise", 32'(busy), 1);
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (done) begin
        got = 1;
        break;
      end
      if (lat == 4) chk("spk_hold", 32'(spikes), 32'(m_prev));
      if (act == 1) begin
        if (lat == 3) begin
          ena = 1'b0; mon_sel = 2'd2;
          #1 snap = v_mon;
        end
        if (lat >= 4 && lat <= 6) begin
          chk("gap_busy", 32'(busy), 1);
          chk("gap_v2", 32'(v_mon), 32'(snap));
        end
        if (lat == 6) ena = 1'b1;
      end
      if (act == 2) begin
        if (lat == 2) begin
          cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 8'd50;
        end
        if (lat == 3) cfg_we = 1'b0;
      end
      if (act == 3) begin
        if (lat == 2) tick = 1'b1;
        if (lat == 3) tick = 1'b0;
      end
    end
    chk("done_seen", 32'(got), 1);
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("spikes", 32'(spikes), 32'(m_spk));
    @(negedge clk);
    chk("done_pulse", 32'(done), 0);
    chk("busy_fall", 32'(busy), 0);
    if (act == 3) begin
      repeat (3) @(negedge clk);
      chk("no_extra", 32'(busy), 0);
    end
    check_all("step");
  endtask

  initial begin
    m_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_all("reset");

    // default config, neuron 0 driven at 100
    for (int t = 1; t <= 7; t++) begin
      run_step(32'd100, 0);
      if (t == 2) begin
        mon_sel = 2'd0;
        #1 chk("t2_v0", 32'(v_mon), 175);
      end
      if (t == 3) chk("t3_spk", 32'(spikes), 1);
    end

    // saturation at the top of the range
    do_reset();
    cfg_wr(2'd0, 8'd255);
    cfg_wr(2'd1, 8'd7);
    run_step(32'h0000_c800, 0);
    run_step(32'h0000_c800, 0);
    chk("sat_spk", 32'(spikes), 2);

    // config write while busy is dropped
    do_reset();
    run_step(32'd60, 2);
    run_step(32'd60, 0);
    cfg_wr(2'd3, 8'd1);
    do_reset();
    cfg_wr(2'd0, 8'd50);
    run_step(32'd60, 0);
    chk("th50_spk", 32'(spikes), 1);

    // extra tick during busy, then enable gap
    do_reset();
    run_step(32'h1020_3040, 3);
    run_step(32'h5060_7080, 1);
    run_step(32'h0a0b_0c0d, 0);

    // reset mid-step after v0 reaches 175
    do_reset();
    run_step(32'd100, 0);
    @(negedge clk);
    tick = 1'b1; cur_in = 32'd100;
    @(posedge clk);
    #1 tick = 1'b0;
    @(posedge clk);
    #1 mon_sel = 2'd0;
    #1 chk("mid_v0", 32'(v_mon), 175);
    rst_n = 1'b0;
    m_reset();
    #1;
    chk("mid_busy", 32'(busy), 0);
    chk("mid_done", 32'(done), 0);
    check_all("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("mid_nodone", 32'(done), 0);
    end
    for (int t = 0; t < 3; t++) run_step(32'd100, 0);

    // randomized config and currents
    do_reset();
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 2) == 0)
        cfg_wr(2'($urandom_range(0, 3)), 8'($urandom));
      run_step($urandom, (i % 7 == 3) ? 1 : 0);
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
